fft_input_loader: RTL
=====================

// Module: fft_input_loader
// PURPOSE
//  Input-side companion to the FFT output reorder buffer. The output buffer turns two samples/cycle back into one.
//  This block does the reverse: it accepts one complex sample per cycle in natural order, buffers whole frames, and
//  emits two samples per cycle in the pairing the first butterfly stage consumes. Ping-pong storage: one bank fills
//  while the other drains. Sits between the sample source and the FFT core.
// PARAMETERS
//  DATA_WIDTH   16   bit width of each real/imag component
//  FFT_LENGTH   16   samples per frame N; power of two, >= 4
//  PAIR_MODE    0    0: pair (x[k], x[k+N/2]) for DIF stage 1; 1: pair (x[2k], x[2k+1])
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           synchronous, active-high reset
//  in_re      in   DATA_WIDTH  input sample, real part
//  in_im      in   DATA_WIDTH  input sample, imaginary part
//  in_valid   in   1           input sample present
//  in_ready   out  1           loader can accept; sample accepted when in_valid && in_ready
//  out1_re    out  DATA_WIDTH  first sample of pair, real part
//  out1_im    out  DATA_WIDTH  first sample of pair, imaginary part
//  out2_re    out  DATA_WIDTH  second sample of pair, real part
//  out2_im    out  DATA_WIDTH  second sample of pair, imaginary part
//  out_valid  out  1           pair on out1/out2 is valid
//  out_ready  in   1           consumer takes pair; transfer when out_valid && out_ready
//  out_last   out  1           high with the final pair (k = N/2-1) of a frame
// BEHAVIOUR
//  - Reset: out_valid=0, out_last=0, out*_re/im=0, in_ready=1 from the cycle after rst is sampled.
//    wr_bank=rd_bank=0, wr_cnt=rd_k=0, full[1:0]=0. Memory contents are not reset.
//    Reset mid-frame discards partial and buffered frames; no stale pair is ever emitted afterwards.
//  - Write side:
//    - in_ready = !full[wr_bank] (registered state only; no combinational path from out_ready).
//    - On accept: bank[wr_bank][wr_cnt] <= {in_re,in_im}; wr_cnt++.
//    - When the accept has wr_cnt==N-1: full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0.
//    - in_valid gaps are allowed anywhere in a frame.
//  - Read side: one-entry output register.
//    - Load condition: full[rd_bank] && (!out_valid || out_ready).
//    - On load: outputs <= selected pair for rd_k; out_valid<=1; out_last<=(rd_k==N/2-1); rd_k++.
//    - Pair indices: PAIR_MODE 0 reads (rd_k, rd_k+N/2); PAIR_MODE 1 reads (2*rd_k, 2*rd_k+1).
//    - Loading rd_k==N/2-1 also clears full[rd_bank], toggles rd_bank and sets rd_k<=0 in that same edge.
//      The bank is freed for writing immediately because the last pair is already held in the output register.
//    - If out_valid && out_ready and no load occurs: out_valid<=0, out_last<=0.
//    - If out_valid && !out_ready: all out* hold stable.
//  - Latency: the last sample of a frame accepted at edge E sets full at E. Pair 0 loads at E+1, so out_valid is
//    high in the cycle after E+1. With out_ready=1 the N/2 pairs follow on consecutive cycles, and a following frame
//    continues with no bubble.
//  - Throughput: drain rate 2 samples/cycle exceeds fill rate 1, so in_ready stays high with out_ready=1.
//    in_ready falls only when both banks are full (consumer stalled).
//  - Simultaneous set of full[wr_bank] and clear of full[rd_bank] on one edge is legal: they are always different
//    banks when both occur.
// TESTING
//  1. N=16, PAIR_MODE=0, ramp re=im=0..15 continuous, out_ready=1 -> pairs (0,8),(1,9)..(7,15) on 8 consecutive
//     cycles. out_valid first high 2 cycles after the sample 15 cycle; out_last only on (7,15).
//  2. Two back-to-back frames 0..15 then 16..31 -> in_ready never drops; second burst is (16,24)..(23,31) with no
//     gap after (7,15).
//  3. out_ready=0 held while feeding 0..47 -> in_ready falls after 32 accepts; (0,8) held stable.
//     Then release out_ready=1 -> all 16 pairs emitted in order, 33rd sample accepted, no loss or duplication.
//  4. Ramp 0..15 with in_valid pattern 1,0,1,0 and out_ready pattern 1,1,0 -> same 8 pairs, each transferred
//     exactly once, in order.
//  5. rst asserted 1 cycle after 5 samples accepted, then frame 100..115 -> out_valid=0 / in_ready=1 after reset;
//     outputs (100,108)..(107,115) only.
//  6. PAIR_MODE=1, ramp 0..15 -> (0,1),(2,3)..(14,15); out_last on (14,15).

Source files
------------

// File: rtl/fft_input_loader.sv
// ---------------------------------------------------------------------------
// fft_input_loader
//
// Input-side companion to the FFT output reorder buffer. Accepts one complex
// sample per cycle in natural order, buffers whole frames in two ping-pong
// banks, and emits two samples per cycle in the pairing consumed by the first
// butterfly stage. One bank fills while the other drains.
//
// Parameters
//   DATA_WIDTH  width of each real/imaginary component
//   FFT_LENGTH  samples per frame N (power of two, >= 4)
//   PAIR_MODE   0: pairs (x[k], x[k+N/2]); 1: pairs (x[2k], x[2k+1])
//
// Ports
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset
//   in_re, in_im         input sample
//   in_valid, in_ready   input handshake (accept when both high)
//   out1_re, out1_im     first sample of the output pair
//   out2_re, out2_im     second sample of the output pair
//   out_valid, out_ready output handshake (transfer when both high)
//   out_last             marks the final pair of a frame
// ---------------------------------------------------------------------------
module fft_input_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int FFT_LENGTH = 16,
  parameter int PAIR_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out1_re,
  output logic [DATA_WIDTH-1:0] out1_im,
  output logic [DATA_WIDTH-1:0] out2_re,
  output logic [DATA_WIDTH-1:0] out2_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int ADDR_W   = $clog2(FFT_LENGTH);
  localparam int K_W      = ADDR_W - 1;
  localparam int HALF     = FFT_LENGTH / 2;
  localparam int SAMPLE_W = 2 * DATA_WIDTH;

  logic [SAMPLE_W-1:0] bank0 [FFT_LENGTH];
  logic [SAMPLE_W-1:0] bank1 [FFT_LENGTH];

  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic [K_W-1:0]    rd_k;
  logic [1:0]        full;

  logic              accept;
  logic              wr_last;
  logic              load;
  logic              rd_last;
  logic [ADDR_W-1:0] idx_a;
  logic [ADDR_W-1:0] idx_b;
  logic [SAMPLE_W-1:0] word_a;
  logic [SAMPLE_W-1:0] word_b;

  // in_ready depends on registered state only, so the consumer's out_ready
  // never ripples combinationally back to the sample source.
  assign in_ready = !full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign wr_last  = (wr_cnt == ADDR_W'(FFT_LENGTH - 1));
  assign load     = full[rd_bank] && (!out_valid || out_ready);
  assign rd_last  = (rd_k == K_W'(HALF - 1));

  // Pair addressing: DIF mode splits the frame into halves (MSB selects half),
  // adjacent mode takes neighbouring samples (LSB selects member of pair).
  generate
    if (PAIR_MODE == 0) begin : g_dif_pairs
      assign idx_a = {1'b0, rd_k};
      assign idx_b = {1'b1, rd_k};
    end else begin : g_adjacent_pairs
      assign idx_a = {rd_k, 1'b0};
      assign idx_b = {rd_k, 1'b1};
    end
  endgenerate

  assign word_a = rd_bank ? bank1[idx_a] : bank0[idx_a];
  assign word_b = rd_bank ? bank1[idx_b] : bank0[idx_b];

  // Sample storage. Contents are deliberately not reset; the full flags and
  // counters decide what is ever read back.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_bank) begin
        bank1[wr_cnt] <= {in_re, in_im};
      end else begin
        bank0[wr_cnt] <= {in_re, in_im};
      end
    end
  end

  // Write pointer: advance per accepted sample, hop to the other bank at the
  // end of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (accept) begin
      if (wr_last) begin
        wr_cnt  <= '0;
        wr_bank <= !wr_bank;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Bank ownership flags. Setting (write side) and clearing (read side) on the
  // same edge always touch different banks, so both updates can coexist.
  // A bank is released as soon as its last pair enters the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (accept && wr_last) begin
        full[wr_bank] <= 1'b1;
      end
      if (load && rd_last) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

  // One-entry output register with read pointer. A load happens whenever the
  // register is empty or being emptied, so frames stream with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank   <= 1'b0;
      rd_k      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out1_re   <= '0;
      out1_im   <= '0;
      out2_re   <= '0;
      out2_im   <= '0;
    end else if (load) begin
      out1_re   <= word_a[SAMPLE_W-1:DATA_WIDTH];
      out1_im   <= word_a[DATA_WIDTH-1:0];
      out2_re   <= word_b[SAMPLE_W-1:DATA_WIDTH];
      out2_im   <= word_b[DATA_WIDTH-1:0];
      out_valid <= 1'b1;
      out_last  <= rd_last;
      if (rd_last) begin
        rd_k    <= '0;
        rd_bank <= !rd_bank;
      end else begin
        rd_k <= rd_k + 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
